// File: rtl/ac_seq_pkg.sv
// ac_seq_pkg: shared types and constants for the ac_seq_ctrl job sequencer.
//   state_e     : sequencer FSM states
//   AC_*_W      : arithmetic core configuration / pixel widths
//   AC_CLR_CYC  : number of cycles the core reset is held low at job start
package ac_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_DONE} state_e;

  localparam int AC_BIAS_W  = 16;
  localparam int AC_BOUND_W = 2;
  localparam int AC_STEP_W  = 3;
  localparam int AC_PIX_W   = 8;
  localparam int AC_CLR_CYC = 2;
endpackage

// File: rtl/ac_seq_ctrl_if.sv
// ac_seq_ctrl_if: bundle of every non-clock signal around the sequencer.
//   slave  : the sequencer's view (takes commands/windows/core results,
//            drives core inputs, result stream and status)
//   master : the surrounding environment's view (buffers + core)
// Signal groups: cmd_* command handshake, win_* window stream, ac_* core
// side, res_* result stream, busy/done/err status.
interface ac_seq_ctrl_if import ac_seq_pkg::*; #(
  parameter int WIN_W = 72,
  parameter int CNT_W = 8
);
  logic                         cmd_valid, cmd_ready;
  logic [AC_BIAS_W-1:0]         cmd_bias;
  logic [AC_BOUND_W-1:0]        cmd_bound;
  logic [AC_STEP_W-1:0]         cmd_step;
  logic                         cmd_relu, cmd_mp;
  logic [CNT_W-1:0]             cmd_nwin, cmd_nout;
  logic                         win_valid, win_ready;
  logic [WIN_W-1:0]             win_data;
  logic [WIN_W-1:0]             ac_in;
  logic                         ac_en;
  logic [AC_BIAS_W-1:0]         ac_bias;
  logic [AC_BOUND_W-1:0]        ac_bound;
  logic [AC_STEP_W-1:0]         ac_step;
  logic                         ac_relu, ac_mp, ac_rst_n;
  logic signed [AC_PIX_W-1:0]   ac_out;
  logic                         ac_out_en;
  logic                         res_valid;
  logic [AC_PIX_W-1:0]          res_data;
  logic                         busy, done, err;

  modport slave (
    input  cmd_valid, cmd_bias, cmd_bound, cmd_step, cmd_relu, cmd_mp,
           cmd_nwin, cmd_nout, win_valid, win_data, ac_out, ac_out_en,
    output cmd_ready, win_ready, ac_in, ac_en, ac_bias, ac_bound, ac_step,
           ac_relu, ac_mp, ac_rst_n, res_valid, res_data, busy, done, err
  );
  modport master (
    output cmd_valid, cmd_bias, cmd_bound, cmd_step, cmd_relu, cmd_mp,
           cmd_nwin, cmd_nout, win_valid, win_data, ac_out, ac_out_en,
    input  cmd_ready, win_ready, ac_in, ac_en, ac_bias, ac_bound, ac_step,
           ac_relu, ac_mp, ac_rst_n, res_valid, res_data, busy, done, err
  );
endinterface

// File: rtl/ac_seq_wdog.sv
// ac_seq_wdog: inactivity counter for the sequencer.
//   clk/reset : clock, synchronous active-high reset
//   en_i      : count enable (job is streaming); counter is held at 0 when low
//   clr_i     : activity seen this cycle; restarts the count
//   tc_o      : terminal count, WDOG_CYC cycles without activity
// cnt_q holds the number of cycles since the last activity, so a clear loads
// 1 (the next cycle is already one cycle after the event).
module ac_seq_wdog #(
  parameter int WDOG_CYC = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CW = $clog2(WDOG_CYC + 1);

  logic [CW-1:0] cnt_q;

  assign tc_o = en_i && !clr_i && (cnt_q == CW'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || !en_i) cnt_q <= '0;
    else if (clr_i)     cnt_q <= CW'(1);
    else if (!tc_o)     cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/ac_seq_ctrl.sv
// ac_seq_ctrl: job sequencer for one arithmetic core.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ac_seq_ctrl_if.slave (command, window stream, core side,
//                result stream, busy/done/err)
// A command is latched in IDLE, the core is held in reset for AC_CLR_CYC
// cycles, windows are streamed into the core and core results forwarded
// until both counts are met, then done pulses.
// Optional build macro AC_SEQ_WATCHDOG_EN: adds an inactivity timeout that
// sets the sticky err flag and ends the job. Without it err is constant 0.
// All outputs are registered from next-state values so they hold reset
// values while reset is high.
module ac_seq_ctrl import ac_seq_pkg::*; #(
  parameter int WIN_W    = 72,
  parameter int CNT_W    = 8,
  parameter int WDOG_CYC = 256
) (
  input logic         clk,
  input logic         reset,
  ac_seq_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d, out_cnt_q, out_cnt_d, nwin_q, nout_q;
  logic [1:0] clr_cnt_q, clr_cnt_d;
  logic [AC_BIAS_W-1:0] bias_q;
  logic [AC_BOUND_W-1:0] bound_q;
  logic [AC_STEP_W-1:0] step_q;
  logic relu_q, mp_q;
  logic cmd_ready_q, win_ready_q, ac_en_q, ac_rst_n_q, res_valid_q, busy_q, done_q;
  logic [WIN_W-1:0] ac_in_q;
  logic [AC_PIX_W-1:0] res_data_q;
  logic run, cmd_acc, win_acc, res_acc, wdog_tc;

  assign run     = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign cmd_acc = bus.cmd_valid && cmd_ready_q;
  assign win_acc = bus.win_valid && win_ready_q;
  // results past nout, or outside streaming, are dropped here
  assign res_acc = bus.ac_out_en && run && (out_cnt_q < nout_q);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    out_cnt_d = out_cnt_q;
    clr_cnt_d = '0;
    case (state_q)
      S_IDLE: if (cmd_acc) begin
        win_cnt_d = '0;
        out_cnt_d = '0;
        state_d   = (bus.cmd_nwin == '0 || bus.cmd_nout == '0) ? S_DONE : S_CLR;
      end
      S_CLR: begin
        if (clr_cnt_q == 2'(AC_CLR_CYC - 1)) state_d = S_FEED;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      S_FEED, S_DRAIN: begin
        if (win_acc) win_cnt_d = win_cnt_q + 1'b1;
        if (res_acc) out_cnt_d = out_cnt_q + 1'b1;
        // completion looks at this cycle's updated counts
        if ((win_cnt_d == nwin_q && out_cnt_d == nout_q) || wdog_tc) state_d = S_DONE;
        else if (win_cnt_d == nwin_q) state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      {win_cnt_q, out_cnt_q, nwin_q, nout_q, clr_cnt_q} <= '0;
      {bias_q, bound_q, step_q, relu_q, mp_q} <= '0;
      {cmd_ready_q, win_ready_q, ac_en_q, ac_rst_n_q} <= '0;
      {res_valid_q, busy_q, done_q} <= '0;
      ac_in_q    <= '0;
      res_data_q <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      out_cnt_q   <= out_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      if (cmd_acc) begin
        nwin_q  <= bus.cmd_nwin;
        nout_q  <= bus.cmd_nout;
        bias_q  <= bus.cmd_bias;
        bound_q <= bus.cmd_bound;
        step_q  <= bus.cmd_step;
        relu_q  <= bus.cmd_relu;
        mp_q    <= bus.cmd_mp;
      end
      cmd_ready_q <= (state_d == S_IDLE);
      win_ready_q <= (state_d == S_FEED) && (win_cnt_d < nwin_q);
      ac_rst_n_q  <= (state_d != S_CLR);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      ac_en_q     <= win_acc;
      if (win_acc) ac_in_q <= bus.win_data;
      res_valid_q <= res_acc;
      if (res_acc) res_data_q <= bus.ac_out;
    end
  end

`ifdef AC_SEQ_WATCHDOG_EN
  logic err_q;

  ac_seq_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
    .clk   (clk),
    .reset (reset),
    .en_i  (run),
    .clr_i (win_acc || res_acc),
    .tc_o  (wdog_tc)
  );

  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (cmd_acc) err_q <= 1'b0;
    else if (wdog_tc) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC == 0);
  assign wdog_tc     = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.win_ready = win_ready_q;
  assign bus.ac_in     = ac_in_q;
  assign bus.ac_en     = ac_en_q;
  assign bus.ac_bias   = bias_q;
  assign bus.ac_bound  = bound_q;
  assign bus.ac_step   = step_q;
  assign bus.ac_relu   = relu_q;
  assign bus.ac_mp     = mp_q;
  assign bus.ac_rst_n  = ac_rst_n_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ac_seq_ctrl.sv
// tb_ac_seq_ctrl: randomized bench for ac_seq_ctrl. Each job is modelled as
// a timeline relative to the command cycle (core reset window, streaming
// phase, result counting, done cycle) with a delayed-response core model.
module tb_ac_seq_ctrl;
  import ac_seq_pkg::*;
  localparam int WIN_W = 72, CNT_W = 8, WDOG_CYC = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ac_seq_ctrl_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus();

  ac_seq_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0, errors = 0;
  logic [WIN_W-1:0] last_in;
  logic [7:0] last_rd;
  bit exp_err_g;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 0; bus.cmd_bias = '0; bus.cmd_bound = '0; bus.cmd_step = '0;
    bus.cmd_relu = 0; bus.cmd_mp = 0; bus.cmd_nwin = '0; bus.cmd_nout = '0;
    bus.win_valid = 0; bus.win_data = '0; bus.ac_out = '0; bus.ac_out_en = 0;
  endtask

  task automatic do_reset(input int n, input string tag);
    drive_idle();
    reset = 1'b1;
    repeat (n) begin
      step();
      chk({tag, "_vals"}, {bus.cmd_ready, bus.win_ready, bus.ac_en, bus.ac_in, bus.ac_bias,
          bus.ac_bound, bus.ac_step, bus.ac_relu, bus.ac_mp, bus.ac_rst_n, bus.res_valid,
          bus.res_data, bus.busy, bus.done, bus.err}, '0);
    end
    reset = 1'b0;
    step();
    chk({tag, "_idle"}, {bus.cmd_ready, bus.ac_rst_n, bus.busy, bus.done, bus.err}, 5'b11000);
    last_in = '0; last_rd = '0; exp_err_g = 0;
  endtask

  // vmode: 0 valid every cycle, 1 one-on/two-off, 2 random.
  // ratio: the core model emits one result per `ratio` windows, at most emit_lim.
  // abort_at: stop after that many accepts (caller resets). hang: expect no done.
  task automatic run_job(input int nwin, input int nout, input int ratio, input int emit_lim,
                         input int vmode, input int dly, input int abort_at, input int hang,
                         input logic [15:0] bias, input bit relu, input bit mp);
    logic [1:0] bnd; logic [2:0] stp; logic [22:0] cfg;
    int c, acc, rcv, emitted, done_at, err_at, last_evt, last_res, budget;
    int en_obs, res_obs, done_n, done_seen, rst_low, rst_first;
    int bad_rdy, bad_en, bad_res, bad_ctl, bad_cfg;
    bit exp_en, exp_rv, act, wv, ov, zero, timed_out, exp_busy, exp_rdy, exp_err;
    logic [WIN_W-1:0] wd; logic [7:0] ov_val;
    int due_q[$]; logic [7:0] val_q[$];
    bnd = 2'($urandom); stp = 3'($urandom);
    cfg = {bias, bnd, stp, relu, mp};
    zero = (nwin == 0) || (nout == 0);
    {acc, rcv, emitted, en_obs, res_obs, done_n, rst_low} = '0;
    {bad_rdy, bad_en, bad_res, bad_ctl, bad_cfg} = '0;
    done_seen = -1; rst_first = -1; err_at = -1; last_res = -1; last_evt = 3;
    done_at = zero ? 1 : -1;
    budget = (hang > 0) ? hang : 3000;
    exp_en = 0; exp_rv = 0; timed_out = 0;
    chk("cmd_ready_pre", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1; bus.cmd_bias = bias; bus.cmd_bound = bnd; bus.cmd_step = stp;
    bus.cmd_relu = relu; bus.cmd_mp = mp;
    bus.cmd_nwin = CNT_W'(nwin); bus.cmd_nout = CNT_W'(nout);
    exp_err_g = 0;
    c = 0;
    while (1) begin
      step(); c++;
      bus.cmd_valid = 0;
      if (bus.ac_rst_n !== 1'b1) begin rst_low++; if (rst_first < 0) rst_first = c; end
      if (bus.ac_en !== exp_en || bus.ac_in !== last_in) bad_en++;
      if (bus.ac_en === 1'b1) en_obs++;
      if (bus.res_valid !== exp_rv || bus.res_data !== last_rd) bad_res++;
      if (bus.res_valid === 1'b1) res_obs++;
      if (bus.done === 1'b1) begin done_n++; done_seen = c; end
      exp_busy = (done_at < 0) || (c <= done_at);
      exp_err  = exp_err_g || (err_at >= 0 && c >= err_at);
      act = (c >= 3) && ((done_at < 0) || (c < done_at));
      exp_rdy = act && (acc < nwin);
      if (bus.win_ready !== exp_rdy) bad_rdy++;
      if (bus.busy !== exp_busy || bus.cmd_ready !== !exp_busy || bus.err !== exp_err) bad_ctl++;
      if ({bus.ac_bias, bus.ac_bound, bus.ac_step, bus.ac_relu, bus.ac_mp} !== cfg) bad_cfg++;
      if (done_at >= 0 && c == done_at + 1) break;
      if (abort_at > 0 && acc == abort_at) break;
      if (c >= budget) begin timed_out = 1; break; end
      case (vmode)
        0:       wv = 1;
        1:       wv = (c % 3 == 0);
        default: wv = ($urandom_range(0, 3) != 0);
      endcase
      wd = {8'($urandom), $urandom, $urandom};
      bus.win_valid = wv; bus.win_data = wd;
      ov = (due_q.size() > 0) && (due_q[0] == c);
      ov_val = ov ? val_q[0] : 8'($urandom);
      if (ov) begin void'(due_q.pop_front()); void'(val_q.pop_front()); end
      bus.ac_out_en = ov; bus.ac_out = ov_val;
      exp_en = wv && exp_rdy;
      if (exp_en) begin
        acc++; last_in = wd; last_evt = c;
        if (acc % ratio == 0 && emitted < emit_lim) begin
          due_q.push_back(c + 1 + dly); val_q.push_back(8'($urandom)); emitted++;
        end
      end
      exp_rv = ov && act && (rcv < nout);
      if (exp_rv) begin rcv++; last_rd = ov_val; last_evt = c; last_res = c; end
      if (act && acc == nwin && rcv == nout) done_at = c + 1;
`ifdef AC_SEQ_WATCHDOG_EN
      else if (act && c - last_evt == WDOG_CYC - 1) begin done_at = c + 1; err_at = c + 1; end
`endif
    end
    bus.win_valid = 0; bus.ac_out_en = 0;
    if (err_at >= 0) exp_err_g = 1;
    chk("win_ready", bad_rdy, 0);
    chk("ac_en_in", bad_en, 0);
    chk("res_stream", bad_res, 0);
    chk("busy_ready_err", bad_ctl, 0);
    chk("cfg_out", bad_cfg, 0);
    if (hang > 0) begin
      chk("hang_busy", bus.busy, 1'b1);
      chk("hang_err", bus.err, 1'b0);
      chk("hang_res_n", res_obs, emit_lim);
    end else if (abort_at == 0) begin
      chk("timeout", timed_out, 1'b0);
      chk("done_cycle", done_seen, done_at);
      chk("done_count", done_n, 1);
      chk("rst_low_n", rst_low, zero ? 0 : 2);
      chk("rst_first", rst_first, zero ? -1 : 1);
      chk("ac_en_n", en_obs, zero ? 0 : nwin);
      chk("res_n", res_obs, zero ? 0 : nout);
      if (err_at >= 0) chk("wdog_gap", done_seen - last_res, WDOG_CYC);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int nw, rt, em, no;
    drive_idle();
    do_reset(2, "rst");
    run_job(64, 64, 1, 64, 0, 3, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_job(64, 16, 4, 16, 1, 3, 0, 0, 16'($urandom), 1'b0, 1'b1);
    run_job(0, 5, 1, 0, 0, 3, 0, 0, 16'($urandom), 1'b1, 1'b0);
    run_job(6, 0, 1, 0, 0, 3, 0, 0, 16'($urandom), 1'b0, 1'b0);
    run_job(64, 64, 1, 64, 2, 3, 20, 0, 16'($urandom), 1'b1, 1'b0);
    do_reset(1, "mid");
    run_job(4, 4, 1, 4, 0, 2, 0, 0, 16'($urandom), 1'b0, 1'b0);
`ifdef AC_SEQ_WATCHDOG_EN
    run_job(16, 16, 1, 15, 0, 3, 0, 0, 16'($urandom), 1'b0, 1'b0);
    run_job(5, 5, 1, 5, 0, 1, 0, 0, 16'($urandom), 1'b0, 1'b0);
`else
    run_job(16, 16, 1, 15, 0, 3, 0, 400, 16'($urandom), 1'b0, 1'b0);
    do_reset(1, "hang");
`endif
    for (int j = 0; j < 8; j++) begin
      nw = $urandom_range(1, 40);
      rt = $urandom_range(1, 3);
      em = nw / rt;
      if (em == 0) begin rt = 1; em = nw; end
      no = em - $urandom_range(0, (em > 2) ? 2 : em - 1);
      run_job(nw, no, rt, em, 2, $urandom_range(1, 5), 0, 0, 16'($urandom),
              1'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ac_seq_ctrl.md
# ac_seq_ctrl

Job sequencer for `arithmetic_core_mod`. It accepts one layer command (bias, bound level, step, ReLU/max-pool enables, window and result counts) and clears the core pipeline. It then streams 9-byte input windows from an upstream buffer into the core, collects the core's `out_en` results and reports completion. It sits between the input window buffer / output feature buffer and a single arithmetic core.

## Interface
- `WIN_W`, 72: window width (9 × 8-bit pixels).
- `CNT_W`, 8: width of window and result counters; max count is 2^CNT_W−1.
- `WDOG_CYC`, 256: watchdog timeout in cycles; used only with `AC_SEQ_WATCHDOG_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_bias` in 16, `cmd_bound` in 2, `cmd_step` in 3, `cmd_relu` in 1, `cmd_mp` in 1: core configuration.
- `cmd_nwin` in CNT_W: windows to feed.
- `cmd_nout` in CNT_W: results to expect.
- `win_valid` in 1, `win_ready` out 1, `win_data` in WIN_W: window stream.
- `ac_in` out WIN_W, `ac_en` out 1: core input and enable.
- `ac_bias` out 16, `ac_bound` out 2, `ac_step` out 3, `ac_relu` out 1, `ac_mp` out 1: core configuration.
- `ac_rst_n` out 1: core reset. Active-low, matching the core.
- `ac_out` in 8 (signed), `ac_out_en` in 1: core result.
- `res_valid` out 1, `res_data` out 8: result to output buffer. No backpressure.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (sticky watchdog flag).

## Operation
- FSM states are IDLE, CLR, FEED, DRAIN, DONE.
- **IDLE**
  - `cmd_ready`=1 only in IDLE.
  - On `cmd_valid`&`cmd_ready`, latch all `cmd_*` into config registers and clear both counters and `err`.
  - If `cmd_nwin`==0 or `cmd_nout`==0, go to DONE. Otherwise go to CLR.
- **CLR**
  - `ac_rst_n`=0 for exactly 2 cycles, then go to FEED.
- **FEED**
  - `win_ready`=1 while `win_cnt`<`nwin`.
  - An accept (`win_valid`&`win_ready`) increments `win_cnt`.
  - When `win_cnt` reaches `nwin`, go to DRAIN.
  - Gaps in `win_valid` are legal. The core sees them as `ac_en`=0 cycles.
- **DRAIN**
  - `win_ready`=0.
  - Wait for `out_cnt`==`nout`.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **Result path** (FEED and DRAIN)
  - Each `ac_out_en` with `out_cnt`<`nout` increments `out_cnt` and is forwarded to `res_valid`/`res_data`.
  - `ac_out_en` pulses beyond `nout`, or outside FEED/DRAIN, are dropped.
- **Completion:** FEED/DRAIN exit to DONE when `win_cnt`==`nwin` and `out_cnt`==`nout`. This is checked against the counter values after the current cycle's updates.
- **Config outputs:** `ac_bias`/`ac_bound`/`ac_step`/`ac_relu`/`ac_mp` come from the config registers and are stable for the whole job.
- **`busy`:** 1 in CLR, FEED, DRAIN and DONE.
- **`ac_in`:** holds its last accepted value when there is no accept.

## Timing
- **Reset values:**
  - `cmd_ready`=0, `win_ready`=0, `ac_en`=0, `ac_in`=0, config outputs 0.
  - `ac_rst_n`=0 while `reset` is high, so the core is held in reset.
  - `res_valid`=0, `res_data`=0, `busy`=0, `done`=0, `err`=0.
  - The first cycle after `reset` falls is IDLE with `cmd_ready`=1 and `ac_rst_n`=1.
- **Command path:**
  - Command accepted at cycle T: `ac_rst_n`=0 during T+1 and T+2.
  - `win_ready` may first be 1 at T+3.
  - If `nwin` or `nout` is 0: `done` at T+1, with no `ac_rst_n` pulse and no `ac_en`.
- **Window path:** window accepted at cycle F → `ac_en`=1 and `ac_in`=`win_data` at F+1. This is 1-cycle registered latency.
- **Result path:** `ac_out_en` at cycle R → `res_valid`=1 and `res_data`=`ac_out` at R+1.
- **Completion:**
  - If the final counted result arrives at cycle R, `done` is 1 at R+1 and IDLE starts at R+2.
  - If the final window accept (cycle F) is what completes the job, `done` is 1 at F+1.
- **Simultaneous window accept and counted result:** both counters update in the same cycle.
- **`reset` high mid-job:** at the next edge all outputs take their reset values and the job is discarded. The next command restarts both counts from 0.

## Configuration
- Macro `AC_SEQ_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on every window accept and every counted `ac_out_en`, and increments otherwise in FEED/DRAIN.
  - When it reaches `WDOG_CYC`, set `err`=1 and go to DONE (`done` pulses).
  - `err` holds until the next command accept or `reset`.
- **Undefined:**
  - `err` is tied to 0 and there is no timeout.
  - A missing result leaves the FSM in DRAIN until `reset`.

## Structure
- Package `ac_seq_pkg` holds:
  - the state enum;
  - widths `AC_BIAS_W`=16, `AC_BOUND_W`=2, `AC_STEP_W`=3, `AC_PIX_W`=8;
  - the CLR length constant (2).
- Sub-module `ac_seq_wdog`: load/clear/terminal-count counter. It is instantiated only under `AC_SEQ_WATCHDOG_EN`.

## Test plan
1. **Reset:** `reset` high 2 cycles, then low → all outputs at reset values during reset. Next cycle `cmd_ready`=1, `ac_rst_n`=1, `busy`=0.
2. **Back-to-back job:**
   - Stimulus: `nwin`=64, `nout`=64, relu=1, mp=0, bias=0, windows every cycle; core model returns `out_en` 3 cycles after each `ac_en`.
   - Required: `ac_rst_n` low exactly 2 cycles; 64 `ac_en`; 64 `res_valid` matching the model; a single `done` one cycle after the 64th result.
3. **Max-pool with gaps:**
   - Stimulus: mp=1, `nwin`=64, `nout`=16, `win_valid` pattern 1-on/2-off, a 65th window offered.
   - Required: `ac_en` reproduces the accept pattern one cycle later; the 65th window is never accepted (`win_ready`=0); 16 results, then `done`.
4. **Zero count:** `cmd_nwin`=0 → `done` at T+1; `ac_en` and `res_valid` stay 0; `ac_rst_n` stays 1.
5. **Reset mid-job:** `reset` pulsed after 20 accepted windows → reset values next cycle. A new job with `nwin`=4, `nout`=4 completes normally with 4 results.
6. **Missing result, watchdog on:** with the macro, `nout`=16 and the model emits 15 → `err`=1 and `done` exactly `WDOG_CYC` cycles after the 15th counted result.
7. **Missing result, watchdog off:** same stimulus without the macro → `busy` remains 1 and `err`=0.
